// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, state encoding and AES-128 byte/column
// transforms used by the round controller and the key-schedule step.
//   NR       - round count (10, AES-128 only)
//   RCON     - round constants indexed by round number (entry 0 unused)
//   sbox, sub_bytes, shift_rows, mix_columns, xtime - cipher primitives
// Byte 0 of a 128-bit block sits in bits [127:120]; column c holds bytes 4c..4c+3.
package aes_pkg;

    localparam int unsigned NR = 10;

    // Indexed directly by the 4-bit round counter; unused slots are zero.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_ctrl_state_e;

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    // S-box as inverse followed by the affine transform, instead of a table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_round_ctrl_if.sv
// aes128_round_ctrl_if: host-side block handshake of the round controller.
//   in_valid/in_ready/plaintext/key   - input pair handshake
//   out_valid/out_ready/ciphertext    - result handshake
//   busy                              - controller is working or holding a result
// master = host side, slave = controller side.
interface aes128_round_ctrl_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );

endinterface

// File: rtl/aes_key_expand_step.sv
// aes_key_expand_step: one AES-128 key-schedule step (combinational).
//   rk      in  128 - current round key
//   rcon    in  8   - round constant for this step
//   rk_next out 128 - next round key
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0   = rk[127:96];
        w1   = rk[95:64];
        w2   = rk[63:32];
        w3   = rk[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        rk_next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: iterative AES-128 encryption, one round per clock.
//   clk  in - rising-edge clock
//   rst  in - synchronous active-high reset
//   bus  slave modport of aes128_round_ctrl_if (input pair, result, busy)
// Accepts a pair in IDLE, runs rounds 1..10 in ROUND with on-the-fly key
// expansion, then holds the result in DONE until the consumer takes it.
module aes128_round_ctrl
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    aes128_round_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ROUND = ST_ROUND;
    localparam logic [1:0] S_DONE  = ST_DONE;
    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [1:0]   state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [127:0] rk_n;
    logic [127:0] sr;
    logic [127:0] round_out;
    logic         last_rnd;

    aes_key_expand_step u_key_step (
        .rk      (rk_q),
        .rcon    (RCON[rnd_q]),
        .rk_next (rk_n)
    );

    // Final round skips MixColumns.
    always_comb begin
        last_rnd  = (rnd_q == LAST_RND);
        sr        = shift_rows(sub_bytes(st_q));
        round_out = (last_rnd ? sr : mix_columns(sr)) ^ rk_n;
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.plaintext ^ bus.key;
                    rk_d    = bus.key;
                    rnd_d   = 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                st_d = round_out;
                rk_d = rk_n;
                if (last_rnd) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

    // Outputs decode registered state only; intermediate round state is not exposed.
    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q == S_ROUND) || (state_q == S_DONE);
    assign bus.ciphertext = (state_q == S_DONE) ? st_q : '0;

endmodule
